// File: rtl/tribus_pkg.sv
// Shared types and range limits for the tri-state bus driver.
package tribus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_TURN,
        S_DRIVE,
        S_CHECK,
        S_SAMPLE
    } state_t;

    localparam int TURN_MIN = 1;
    localparam int TURN_MAX = 3;
    localparam int HOLD_MIN = 1;
    localparam int HOLD_MAX = 4;

    // Wide enough to hold the largest reload value, HOLD_MAX-1.
    localparam int CNT_W = 2;

endpackage

// File: rtl/tribus_cnt.sv
// Down-counter shared by the turnaround and drive phases.
module tribus_cnt
    import tribus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Saturates at zero so a stray decrement cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tribus_driver.sv
// Arbitrated tri-state bus master: turnaround, drive, keeper check and sample.
module tribus_driver
    import tribus_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TURN  = 1,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             bus_req,
    input  logic             gnt,
    output logic [WIDTH-1:0] bus_o,
    output logic             bus_oe,
    input  logic [WIDTH-1:0] bus_i,
    output logic             keep_err,
    input  logic             keep_err_clr
);

    localparam int TURN_C = (TURN < TURN_MIN) ? TURN_MIN : (TURN > TURN_MAX) ? TURN_MAX : TURN;
    localparam int HOLD_C = (HOLD < HOLD_MIN) ? HOLD_MIN : (HOLD > HOLD_MAX) ? HOLD_MAX : HOLD;
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_C - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_C - 1);

    state_t           state;
    logic             cur_wr;
    logic [WIDTH-1:0] cur_data;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    tribus_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Counter reloads on entry to TURN and DRIVE; an abort leaves it stale
    // because the next grant reloads it anyway.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            S_ARB: begin
                if (gnt) begin
                    cnt_load = 1'b1;
                    cnt_val  = TURN_LOAD;
                end
            end
            S_TURN: begin
                if (gnt) begin
                    if (cnt_zero) begin
                        cnt_load = cur_wr;
                        cnt_val  = HOLD_LOAD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            S_DRIVE: begin
                cnt_dec = gnt && !cnt_zero;
            end
            default: ;
        endcase
    end

    assign req_ready = (state == S_IDLE);

    // Losing the grant in TURN, DRIVE or SAMPLE drops back to ARB and
    // releases the pads on the same edge, so OE never follows a GNT=0 cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_wr    <= 1'b0;
            cur_data  <= '0;
            bus_req   <= 1'b0;
            bus_oe    <= 1'b0;
            bus_o     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            keep_err  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (keep_err_clr) begin
                keep_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cur_wr   <= req_wr;
                        cur_data <= req_data;
                        bus_req  <= 1'b1;
                        state    <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (gnt) begin
                        state <= S_TURN;
                    end
                end
                S_TURN: begin
                    if (!gnt) begin
                        state <= S_ARB;
                    end else if (cnt_zero) begin
                        if (cur_wr) begin
                            bus_oe <= 1'b1;
                            bus_o  <= cur_data;
                            state  <= S_DRIVE;
                        end else begin
                            state <= S_SAMPLE;
                        end
                    end
                end
                S_DRIVE: begin
                    if (!gnt) begin
                        bus_oe <= 1'b0;
                        state  <= S_ARB;
                    end else if (cnt_zero) begin
                        bus_oe <= 1'b0;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bus_i != cur_data) begin
                        keep_err <= 1'b1;
                    end
                    rsp_data  <= cur_data;
                    rsp_valid <= 1'b1;
                    bus_req   <= 1'b0;
                    state     <= S_IDLE;
                end
                S_SAMPLE: begin
                    if (!gnt) begin
                        state <= S_ARB;
                    end else begin
                        rsp_data  <= bus_i;
                        rsp_valid <= 1'b1;
                        bus_req   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tribus_driver.sv
// Directed bench for tribus_driver with a transaction-level reference model.
module tb_tribus_driver;

    localparam int W    = 8;
    localparam int TURN = 1;
    localparam int HOLD = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_wr = 1'b0;
    logic [W-1:0] req_data = '0;
    logic         gnt = 1'b1;
    logic         keep_err_clr = 1'b0;
    logic         force_en = 1'b0;
    logic [W-1:0] force_val = '0;
    logic [W-1:0] keeper = '0;
    logic [W-1:0] bus_i;

    logic         req_ready;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic         bus_req;
    logic [W-1:0] bus_o;
    logic         bus_oe;
    logic         keep_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int oe_count = 0;
    int rsp_count = 0;
    int acc_cyc = 0;
    bit check_en = 1'b0;

    // Reference model state: a pending transaction plus the edge it was granted.
    bit           m_busy, m_arb, m_wr;
    logic [W-1:0] m_data;
    int           m_n, m_g;
    bit           m_oe, m_rv, m_ke, m_req;
    logic [W-1:0] m_bo, m_rd;

    tribus_driver #(.WIDTH(W), .TURN(TURN), .HOLD(HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .bus_req      (bus_req),
        .gnt          (gnt),
        .bus_o        (bus_o),
        .bus_oe       (bus_oe),
        .bus_i        (bus_i),
        .keep_err     (keep_err),
        .keep_err_clr (keep_err_clr)
    );

    always #5 clk = ~clk;

    assign bus_i = force_en ? force_val : (bus_oe ? bus_o : keeper);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_oe) keeper <= bus_o;
    end

    always @(negedge clk) begin
        if (bus_oe === 1'b1) oe_count <= oe_count + 1;
        if (rsp_valid === 1'b1) rsp_count <= rsp_count + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // The model schedules each attempt by edges since the grant: TURN edges of
    // turnaround, HOLD of drive for writes, then one check/sample edge.
    initial begin
        int k, last;
        bit set;
        m_busy = 0; m_arb = 0; m_wr = 0; m_data = '0; m_n = 0; m_g = 0;
        m_oe = 0; m_rv = 0; m_ke = 0; m_req = 0; m_bo = '0; m_rd = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 0; m_arb = 0; m_oe = 0; m_rv = 0; m_ke = 0;
                m_req = 0; m_bo = '0; m_rd = '0;
            end else begin
                m_n++;
                m_rv = 0;
                set = 0;
                if (!m_busy) begin
                    if (req_valid) begin
                        m_busy = 1; m_arb = 1; m_wr = req_wr; m_data = req_data;
                    end
                end else if (m_arb) begin
                    if (gnt) begin
                        m_arb = 0; m_g = m_n;
                    end
                end else begin
                    k = m_n - m_g;
                    last = m_wr ? TURN + HOLD + 1 : TURN + 1;
                    if (!gnt && (m_wr ? (k < last) : (k <= last))) begin
                        m_arb = 1;
                    end else if (k == last) begin
                        m_busy = 0;
                        m_rv = 1;
                        if (m_wr) begin
                            m_rd = m_data;
                            set = (bus_i != m_data);
                        end else begin
                            m_rd = bus_i;
                        end
                    end
                end
                if (set) m_ke = 1;
                else if (keep_err_clr) m_ke = 0;
                m_req = m_busy;
                k = m_n - m_g;
                m_oe = m_busy && !m_arb && m_wr && (k >= TURN) && (k < TURN + HOLD);
                if (m_oe) m_bo = m_data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("model_req_ready", req_ready, !m_busy);
                checkOutput("model_bus_req", bus_req, m_req);
                checkOutput("model_bus_oe", bus_oe, m_oe);
                checkOutput("model_bus_o", bus_o, m_bo);
                checkOutput("model_rsp_valid", rsp_valid, m_rv);
                checkOutput("model_rsp_data", rsp_data, m_rd);
                checkOutput("model_keep_err", keep_err, m_ke);
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [W-1:0] d);
        @(negedge clk);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_data  = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic waitRsp(input int start, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = cyc - start;
                break;
            end
        end
    endtask

    task automatic waitOe(input logic val, input string name);
        bit seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_oe == val) begin
                seen = 1;
                break;
            end
        end
        if (!seen) checkOutput(name, bus_oe, val);
    endtask

    initial begin
        int lat, g_cyc, oe0, rsp0;
        rst = 1'b1;
        @(posedge clk);
        #1 check_en = 1'b1;
        @(negedge clk);
        checkOutput("reset_state", {req_ready, bus_req, bus_oe, rsp_valid, keep_err}, 5'b10000);
        checkOutput("reset_bus_o", bus_o, 0);
        rst = 1'b0;

        // Plain write with loopback keeper.
        oe0 = oe_count;
        applyStimulus(1'b1, 8'hA5);
        waitRsp(acc_cyc, lat);
        checkOutput("wr_latency", lat, 5);
        checkOutput("wr_rsp_data", rsp_data, 8'hA5);
        checkOutput("wr_keep_err", keep_err, 0);
        @(negedge clk);
        checkOutput("wr_oe_cycles", oe_count - oe0, 2);

        // Keeper fails during the check cycle.
        applyStimulus(1'b1, 8'hA5);
        waitOe(1'b1, "ke_oe_rise");
        waitOe(1'b0, "ke_oe_fall");
        force_val = 8'h00;
        force_en  = 1'b1;
        @(negedge clk);
        force_en = 1'b0;
        checkOutput("ke_rsp_valid", rsp_valid, 1);
        checkOutput("ke_set", keep_err, 1);
        repeat (3) @(negedge clk);
        checkOutput("ke_sticky", keep_err, 1);
        keep_err_clr = 1'b1;
        @(negedge clk);
        keep_err_clr = 1'b0;
        checkOutput("ke_cleared", keep_err, 0);

        // Read never drives the bus.
        force_val = 8'h3C;
        force_en  = 1'b1;
        oe0 = oe_count;
        applyStimulus(1'b0, 8'h00);
        waitRsp(acc_cyc, lat);
        checkOutput("rd_latency", lat, 3);
        checkOutput("rd_rsp_data", rsp_data, 8'h3C);
        @(negedge clk);
        checkOutput("rd_oe_cycles", oe_count - oe0, 0);
        force_en = 1'b0;

        // Grant withheld for four cycles after accept.
        @(negedge clk);
        gnt = 1'b0;
        applyStimulus(1'b1, 8'hC3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("arb_hold", {req_ready, bus_req, bus_oe}, 3'b010);
        end
        @(posedge clk);
        #1 gnt = 1'b1;
        @(posedge clk);
        #1 g_cyc = cyc;
        waitRsp(g_cyc, lat);
        checkOutput("arb_latency", lat, 4);
        checkOutput("arb_rsp_data", rsp_data, 8'hC3);

        // Grant lost in the first drive cycle forces a full retry.
        @(negedge clk);
        oe0  = oe_count;
        rsp0 = rsp_count;
        applyStimulus(1'b1, 8'h5A);
        waitOe(1'b1, "abort_oe_rise");
        gnt = 1'b0;
        @(negedge clk);
        checkOutput("abort_oe_off", bus_oe, 0);
        gnt = 1'b1;
        waitRsp(acc_cyc, lat);
        checkOutput("abort_latency", lat, 8);
        checkOutput("abort_rsp_data", rsp_data, 8'h5A);
        repeat (4) @(negedge clk);
        checkOutput("abort_oe_cycles", oe_count - oe0, 3);
        checkOutput("abort_rsp_count", rsp_count - rsp0, 1);

        // Reset in the middle of a drive.
        applyStimulus(1'b1, 8'h77);
        waitOe(1'b1, "rst_oe_rise");
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_async_oe", bus_oe, 0);
        checkOutput("rst_async_req", bus_req, 0);
        @(negedge clk);
        rst  = 1'b0;
        rsp0 = rsp_count;
        repeat (8) @(negedge clk);
        checkOutput("rst_no_rsp", rsp_count - rsp0, 0);
        checkOutput("rst_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tribus_driver.md
TRIBUS_DRIVER -- requirements
Module: tribus_driver

Interface
REQ-001: Parameter WIDTH, default 8, shared bus width in bits (1..32).
REQ-002: Parameter TURN, default 1, turnaround cycles (bus left to keepers) before driving or sampling (1..3).
REQ-003: Parameter HOLD, default 2, cycles the bus is actively driven per write (1..4).
REQ-004: CLK  input  1  single clock; all state on rising edge.
REQ-005: RST  input  1  asynchronous, active-high reset.
REQ-006: REQ_VALID  input  1  transaction request valid.
REQ-007: REQ_READY  output  1  block can accept a request.
REQ-008: REQ_WR  input  1  1 = write (drive bus), 0 = read (sample bus).
REQ-009: REQ_DATA  input  WIDTH  write data.
REQ-010: RSP_VALID  output  1  one-cycle completion pulse.
REQ-011: RSP_DATA  output  WIDTH  write: data driven; read: bus value sampled.
REQ-012: BUS_REQ  output  1  request for bus ownership to the external arbiter.
REQ-013: GNT  input  1  bus ownership grant.
REQ-014: BUS_O  output  WIDTH  data to the tri-state pad driver.
REQ-015: BUS_OE  output  1  tri-state enable; 0 = released, bus held by keeper cells.
REQ-016: BUS_I  input  WIDTH  bus value as seen at the pads (keeper-held when undriven).
REQ-017: KEEP_ERR  output  1  sticky: keeper failed to hold the last driven value.
REQ-018: KEEP_ERR_CLR  input  1  synchronous clear of KEEP_ERR.

Function
REQ-019: FSM states IDLE, ARB, TURN, DRIVE, CHECK, SAMPLE; state held in one register.
REQ-020: REQ_READY = 1 only in IDLE; a request is accepted on the edge where REQ_VALID and REQ_READY are both 1, and REQ_WR and REQ_DATA are captured at that edge.
REQ-021: IDLE -> ARB on accept; BUS_REQ = 1 in ARB, TURN, DRIVE, CHECK and SAMPLE, and 0 otherwise.
REQ-022: ARB -> TURN on the edge where GNT = 1; the turnaround counter loads TURN-1.
REQ-023: TURN lasts exactly TURN cycles with BUS_OE = 0; it then moves to DRIVE if REQ_WR = 1, else to SAMPLE.
REQ-024: DRIVE lasts HOLD cycles with BUS_OE = 1 and BUS_O = captured data, then moves to CHECK.
REQ-025: CHECK lasts 1 cycle with BUS_OE = 0; at its closing edge, BUS_I != captured data sets KEEP_ERR, and the FSM moves to IDLE.
REQ-026: SAMPLE lasts 1 cycle with BUS_OE = 0; at its closing edge BUS_I is registered into RSP_DATA, and the FSM moves to IDLE.
REQ-027: RSP_VALID is registered and equals 1 for exactly the first IDLE cycle after CHECK or SAMPLE; REQ_READY is also 1 in that cycle.
REQ-028: GNT = 0 sampled in TURN, DRIVE or SAMPLE aborts to ARB at that edge, with BUS_OE = 0 from the next cycle; the transaction then retries with full TURN and HOLD counts, and no RSP_VALID is issued for the aborted attempt.
REQ-029: BUS_OE and BUS_O are driven directly from flops, never from combinational decode.
REQ-030: BUS_O holds its last value whenever BUS_OE = 0.
REQ-031: BUS_OE never goes 1 in the cycle immediately following a cycle with GNT = 0.
REQ-032: Latency with GNT held at 1: write RSP_VALID 1+TURN+HOLD+1 cycles after the accept edge (5 at defaults); read 1+TURN+1 cycles (3 at defaults).
REQ-033: If KEEP_ERR_CLR = 1 in the same cycle as a mismatch, the set wins.

Reset
REQ-034: RST asynchronously forces state IDLE, BUS_OE = 0, BUS_REQ = 0, RSP_VALID = 0, KEEP_ERR = 0, BUS_O = 0, RSP_DATA = 0, and all counters to 0.
REQ-035: RST asserted mid-transaction releases the bus immediately, and the transaction is discarded with no response.

Structure
REQ-036: Package tribus_pkg holds the FSM state typedef and the TURN and HOLD range-limit constants.
REQ-037: The turnaround and drive counting is one down-counter sub-module, tribus_cnt (load, decrement, zero flag).

Verification
REQ-038: Write 0xA5 with defaults, GNT tied to 1, BUS_I looped from BUS_O while OE=1 and held otherwise -> BUS_OE=1 for 2 cycles, RSP_VALID at +5 with RSP_DATA=0xA5, KEEP_ERR=0.
REQ-039: Same write, but force BUS_I=0x00 in CHECK -> KEEP_ERR=1 and stays 1; KEEP_ERR_CLR pulse -> 0.
REQ-040: Read with BUS_I=0x3C -> BUS_OE never 1, RSP_VALID at +3, RSP_DATA=0x3C.
REQ-041: GNT held 0 for 4 cycles after a write request is accepted -> FSM stays in ARB with BUS_REQ=1 and BUS_OE=0; GNT then 1 -> RSP_VALID 4 cycles later.
REQ-042: GNT dropped during the first DRIVE cycle -> BUS_OE=0 next cycle, then a full retry with 2 DRIVE cycles and a single RSP_VALID.
REQ-043: RST pulsed during DRIVE -> BUS_OE=0 asynchronously, no RSP_VALID, REQ_READY=1 after reset release.
